// File: rtl/jk_updown_counter_if.sv
// Control and observation bundle for the JK up/down modulo counter.
// The master drives the controls and the slave returns the count, excitations and flags.
interface jk_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;
    logic             tc;
    logic             wrap;
    logic             err;

    modport master (
        output en, up, load, din,
        input  q, j_exc, k_exc, tc, wrap, err
    );

    modport slave (
        input  en, up, load, din,
        output q, j_exc, k_exc, tc, wrap, err
    );
endinterface

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from per-bit JK flops, with load, terminal count and wrap pulse.
// One-edge latency from sampled controls to q; no backpressure, the counter acts on every enabled edge.
module jk_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_updown_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;
    logic             din_bad;
    logic             tc;
    logic             wrap_r;
    logic             err_r;

    // Next-state selection: load beats enable, enable beats hold.
    // Out-of-range states (only reachable by forcing) fold to 0 when counting up.
    always_comb begin
        nq      = q_r;
        din_bad = 1'b0;
        if (bus.load) begin
            if (bus.din <= LAST) begin
                nq = bus.din;
            end else begin
                nq      = '0;
                din_bad = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                nq = (q_r >= LAST) ? '0 : q_r + 1'b1;
            end else begin
                nq = (q_r == '0) ? LAST : q_r - 1'b1;
            end
        end
    end

    // Minimal excitation: set only on 0->1, clear only on 1->0, so J and K are never both high.
    always_comb begin
        j_exc = ~q_r & nq;
        k_exc = q_r & ~nq;
    end

    always_comb begin
        tc = bus.en & ~bus.load &
             ((bus.up & (q_r == LAST)) | (~bus.up & (q_r == '0)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j_exc[i], k_exc[i]})
                    2'b01:   q_r[i] <= 1'b0;
                    2'b10:   q_r[i] <= 1'b1;
                    2'b11:   q_r[i] <= ~q_r[i];
                    default: q_r[i] <= q_r[i];
                endcase
            end
        end
    end

    // tc already excludes load cycles, so a load can never produce a wrap pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            wrap_r <= tc;
            err_r  <= err_r | din_bad;
        end
    end

    assign bus.q     = q_r;
    assign bus.j_exc = j_exc;
    assign bus.k_exc = k_exc;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_r;
    assign bus.err   = err_r;

endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter register width in bits.
REQ-002 Parameter MODULUS, default 10, SHALL set the count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 en  input  1  SHALL be the count enable; 1 = advance one step this edge.
REQ-006 up  input  1  SHALL select direction: 1 = up, 0 = down.
REQ-007 load  input  1  SHALL be the synchronous parallel load; it takes priority over en.
REQ-008 din  input  WIDTH  SHALL be the parallel load value.
REQ-009 q  output  WIDTH  SHALL be the registered count.
REQ-010 j_exc  output  WIDTH  SHALL be the per-bit J excitation for the current cycle (combinational).
REQ-011 k_exc  output  WIDTH  SHALL be the per-bit K excitation for the current cycle (combinational).
REQ-012 tc  output  1  SHALL be the terminal-count flag (combinational).
REQ-013 wrap  output  1  SHALL be a registered one-cycle pulse marking a completed wrap.
REQ-014 err  output  1  SHALL be a sticky flag for an illegal load value.

Function
REQ-015 Next-state nq SHALL be determined with priority load > en > hold.
REQ-016 load=1, din < MODULUS: nq = din.
REQ-017 load=1, din >= MODULUS: nq = 0 and err set to 1 on that edge.
REQ-018 load=0, en=1, up=1: nq = 0 if q == MODULUS-1, else q+1.
REQ-019 load=0, en=1, up=0: nq = MODULUS-1 if q == 0, else q-1.
REQ-020 load=0, en=0: nq = q.
REQ-021 Per bit i, j_exc[i] SHALL equal ~q[i] & nq[i] and k_exc[i] SHALL equal q[i] & ~nq[i]; don't-care cases are driven to 0.
REQ-022 Each bit of q SHALL update using JK semantics on (j_exc[i], k_exc[i]): 00 hold, 01 clear, 10 set, 11 toggle.
REQ-023 Under REQ-021, the JK update SHALL always yield q = nq after the edge; j_exc[i] & k_exc[i] never both 1.
REQ-024 tc SHALL be en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)).
REQ-025 wrap SHALL be 1 for exactly the one cycle following an edge on which tc was 1; it is 0 otherwise.
REQ-026 A load SHALL never assert wrap, including a load to 0 or MODULUS-1.
REQ-027 A direction change SHALL take effect on the same edge on which up is sampled; there is no extra latency.
REQ-028 Count latency SHALL be one edge: q reflects nq one clock after inputs are sampled.
REQ-029 err SHALL remain 1 until reset; there is no other clear path.
REQ-030 Behaviour for q >= MODULUS is unreachable by design; if forced, en=1 SHALL produce nq = 0 for up and q-1 for down.

Reset
REQ-031 While rst=0, q SHALL be 0, wrap 0 and err 0, immediately and regardless of clk.
REQ-032 Because j_exc, k_exc and tc are combinational, during reset they SHALL reflect q=0 and the current inputs.
REQ-033 Reset asserted mid-count SHALL abort the count with no wrap pulse; the first edge after rst returns to 1 SHALL evaluate from q=0.

Verification (WIDTH=4, MODULUS=10)
REQ-034 Reset, then en=1, up=1 for 12 edges -> q = 1..9, 0, 1, 2; tc=1 while q=9; wrap=1 only in the cycle where q=0 after the 9->0 edge.
REQ-035 Load din=0, then en=1, up=0 -> q = 9, 8, 7; tc=1 in the q=0 cycle; wrap pulse after the 0->9 edge.
REQ-036 q=7 (0111), up count -> q=8, with j_exc=1000 and k_exc=0111 before the edge; at every cycle, j_exc & k_exc == 0.
REQ-037 load=1, din=12 -> q=0, err=1 and err stays 1; a following load din=5 gives q=5 with err still 1.
REQ-038 load=1 and en=1 together, din=3 -> q=3, no wrap; load din=9 with en=1, up=1 -> q=9, tc=0 during the load cycle.
REQ-039 Drop rst to 0 asynchronously mid-cycle at q=6 -> q=0, wrap=0, err=0 before the next clk edge; release -> counting resumes 1, 2, ...
